// File: rtl/therm_count_decoder.sv
// Recovers a 0..WIDTH level from thermometer-coded slide switches: synchronise, debounce, validate, commit.
// Optional build macro THERM_POPCOUNT_FALLBACK_EN: invalid patterns commit a saturated popcount instead of holding count.
module therm_count_decoder #(
    parameter int WIDTH           = 16,
    parameter int CNT_W           = 6,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic             basys_clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw,
    output logic [CNT_W-1:0] count,
    output logic             count_valid,
    output logic             code_err,
    output logic             busy
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [CNT_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            acc = acc + CNT_W'(v[i]);
        end
        return acc;
    endfunction

    // A thermometer code is 2^k-1, so adding one clears every set bit (all-ones wraps to zero).
    function automatic logic is_therm(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] inc;
        inc = v + WIDTH'(1);
        return ((inc & v) == '0);
    endfunction

    function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] c);
        logic [CNT_W-1:0] res;
        if (c > CNT_W'(WIDTH)) begin
            res = CNT_W'(WIDTH);
        end else begin
            res = c;
        end
        return res;
    endfunction

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] sw_s;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [WIDTH-1:0] committed_q, committed_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             count_valid_q, count_valid_d;
    logic             code_err_q, code_err_d;
    logic             busy_q, busy_d;
    state_t           state_q, state_d;

    assign sw_s = sync2_q;

    // Two-flop synchroniser for the asynchronous switch inputs.
    always_ff @(posedge basys_clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sw;
            sync2_q <= sync1_q;
        end
    end

    // State, debounce datapath and registered outputs.
    always_ff @(posedge basys_clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cand_q        <= '0;
            committed_q   <= '0;
            db_cnt_q      <= '0;
            count_q       <= '0;
            count_valid_q <= 1'b0;
            code_err_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cand_q        <= cand_d;
            committed_q   <= committed_d;
            db_cnt_q      <= db_cnt_d;
            count_q       <= count_d;
            count_valid_q <= count_valid_d;
            code_err_q    <= code_err_d;
            busy_q        <= busy_d;
        end
    end

    // Next-state and commit logic.
    always_comb begin
        state_d       = state_q;
        cand_d        = cand_q;
        committed_d   = committed_q;
        db_cnt_d      = db_cnt_q;
        count_d       = count_q;
        code_err_d    = code_err_q;
        count_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sw_s != committed_q) begin
                    cand_d   = sw_s;
                    db_cnt_d = '0;
                    state_d  = ST_SETTLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                // A return to the committed value still settles and commits (pulse, same count).
                if (sw_s != cand_q) begin
                    cand_d   = sw_s;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d = ST_COMMIT;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            ST_COMMIT: begin
                committed_d   = cand_q;
                count_valid_d = 1'b1;
                if (is_therm(cand_q)) begin
                    count_d    = popcount(cand_q);
                    code_err_d = 1'b0;
                end else begin
`ifdef THERM_POPCOUNT_FALLBACK_EN
                    count_d    = sat_count(popcount(cand_q));
`else
                    count_d    = count_q;
`endif
                    code_err_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

`ifndef THERM_POPCOUNT_FALLBACK_EN
    logic unused_sat_s;
    assign unused_sat_s = ^sat_count(count_q);
`endif

    assign count       = count_q;
    assign count_valid = count_valid_q;
    assign code_err    = code_err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_therm_count_decoder.sv
// Self-checking bench for therm_count_decoder (DEBOUNCE_CYCLES=4): directed table, corner sequences, random vs model.
module tb_therm_count_decoder;

    logic        clk;
    logic        rst;
    logic [15:0] sw;
    logic [5:0]  count;
    logic        count_valid;
    logic        code_err;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int pulses;

    logic [15:0] m_committed;
    logic [5:0]  m_count;
    logic        m_err;

    therm_count_decoder #(
        .WIDTH(16),
        .CNT_W(6),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .basys_clk  (clk),
        .reset      (rst),
        .sw         (sw),
        .count      (count),
        .count_valid(count_valid),
        .code_err   (code_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pat;
        logic [5:0]  exp_off;
        logic [5:0]  exp_on;
        logic        exp_err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    // One clock, sampled 1 time unit after the rising edge; counts pulses.
    task automatic step();
        @(posedge clk);
        #1;
        if (count_valid === 1'b1) pulses++;
    endtask

    task automatic apply_vec(input string name, input logic [15:0] pat, input int exp_pulses,
                             input logic [5:0] exp_cnt, input logic exp_err);
        sw = pat;
        pulses = 0;
        repeat (14) step();
        check({name, "_pulses"}, pulses, exp_pulses);
        check({name, "_count"}, count, exp_cnt);
        check({name, "_err"}, code_err, exp_err);
        check({name, "_busy"}, busy, 1'b0);
        m_committed = pat;
        m_count = exp_cnt;
        m_err = exp_err;
    endtask

    // Reference: length of the run of ones from bit 0; valid iff it accounts for every set bit.
    task automatic model_expect(input logic [15:0] pat, output int ep, output logic [5:0] ec, output logic ee);
        int run;
        bit stop;
        run = 0;
        stop = 0;
        for (int i = 0; i < 16; i++) begin
            if (!stop && pat[i]) run++;
            else stop = 1;
        end
        if (pat == m_committed) begin
            ep = 0; ec = m_count; ee = m_err;
        end else if ($countones(pat) == run) begin
            ep = 1; ec = 6'(run); ee = 1'b0;
        end else begin
            ep = 1;
`ifdef THERM_POPCOUNT_FALLBACK_EN
            ec = 6'($countones(pat));
`else
            ec = m_count;
`endif
            ee = 1'b1;
        end
    endtask

    vec_t vecs[7];

    initial begin
        int ep;
        logic [5:0] ec;
        logic ee;
        logic [15:0] p;
        int k;
        bit found;

        vecs[0] = '{16'hFFFF, 6'd16, 6'd16, 1'b0};
        vecs[1] = '{16'h0000, 6'd0,  6'd0,  1'b0};
        vecs[2] = '{16'h0007, 6'd3,  6'd3,  1'b0};
        vecs[3] = '{16'h0005, 6'd3,  6'd2,  1'b1};
        vecs[4] = '{16'h0001, 6'd1,  6'd1,  1'b0};
        vecs[5] = '{16'h8000, 6'd1,  6'd1,  1'b1};
        vecs[6] = '{16'hFFFE, 6'd1,  6'd15, 1'b1};

        rst = 1'b1;
        sw = 16'h0000;
        pulses = 0;
        repeat (3) step();
        rst = 1'b0;
        pulses = 0;
        repeat (20) step();
        check("rst_count", count, 6'd0);
        check("rst_err", code_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_pulses", pulses, 0);

        // Clean edge: the pulse must land exactly 8 cycles later.
        sw = 16'h00FF;
        pulses = 0;
        repeat (3) step();
        check("lat_busy", busy, 1'b1);
        repeat (4) step();
        check("lat_early_pulses", pulses, 0);
        step();
        check("lat_valid", count_valid, 1'b1);
        check("lat_count", count, 6'd8);
        check("lat_err", code_err, 1'b0);
        repeat (6) step();
        check("lat_pulses", pulses, 1);

        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            sw = (i % 2 == 0) ? 16'h0007 : 16'h000F;
            repeat (2) step();
        end
        check("toggle_no_commit", pulses, 0);
        check("toggle_count_held", count, 6'd8);
        apply_vec("toggle_hold", 16'h000F, 1, 6'd4, 1'b0);

        for (int i = 0; i < 7; i++) begin
`ifdef THERM_POPCOUNT_FALLBACK_EN
            apply_vec($sformatf("vec%0d", i), vecs[i].pat, 1, vecs[i].exp_on, vecs[i].exp_err);
`else
            apply_vec($sformatf("vec%0d", i), vecs[i].pat, 1, vecs[i].exp_off, vecs[i].exp_err);
`endif
        end
        apply_vec("vec_final", 16'h0001, 1, 6'd1, 1'b0);

        // Reset two cycles into the settle of 0x0003.
        sw = 16'h0003;
        pulses = 0;
        repeat (5) step();
        rst = 1'b1;
        #1;
        check("midrst_count", count, 6'd0);
        check("midrst_err", code_err, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_valid", count_valid, 1'b0);
        repeat (2) step();
        rst = 1'b0;
        check("midrst_pulses", pulses, 0);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (count_valid === 1'b1) found = 1;
        end
        check("midrst_commit_seen", found, 1'b1);
        check("midrst_count2", count, 6'd2);
        check("midrst_err2", code_err, 1'b0);
        repeat (4) step();
        m_committed = 16'h0003;
        m_count = 6'd2;
        m_err = 1'b0;

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0: begin
                    k = $urandom_range(0, 16);
                    p = (k == 16) ? 16'hFFFF : 16'((32'd1 << k) - 32'd1);
                end
                1: p = 16'($urandom);
                default: p = m_committed;
            endcase
            model_expect(p, ep, ec, ee);
            apply_vec($sformatf("rand%0d", i), p, ep, ec, ee);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
